// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard for the decode stage.
// Each architectural register r (1..31) has a 2-bit pending counter. It is
// loaded with the producer latency when a writer issues, and counts down
// while the pipeline advances. A decode instruction whose sources are still
// pending must stall.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   id_*              decode-stage instruction fields
//   ex_ready          execute accepts an instruction (0 freezes the pipeline)
//   flush             kill the decode instruction this cycle
//   issue, stall      combinational issue / hold decisions
//   ex_bubble         registered: execute holds a NOP this cycle
//   busy_mask         combinational: bit r set while register r is pending
//   stall_count       registered saturating stall-cycle counter
module hazard_scoreboard #(
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest_addr,
    input  logic        id_writes,
    input  logic        id_is_load,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        issue,
    output logic        stall,
    output logic        ex_bubble,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_count
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STALL_W  = 16;

    localparam logic [CNT_W-1:0]   ALU_CNT   = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0]   LOAD_CNT  = CNT_W'(LOAD_LAT);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             rs_pending;
    logic             rt_pending;
    logic             hazard;
    logic             load_dest;

    // Hazard is judged on the counters as they stand before this edge, so a
    // self-dependent instruction never sees its own freshly loaded counter.
    always_comb begin
        rs_pending = id_uses_rs && (id_rs_addr != 5'd0) && (cnt[id_rs_addr] != '0);
        rt_pending = id_uses_rt && (id_rt_addr != 5'd0) && (cnt[id_rt_addr] != '0);
        hazard     = rs_pending || rt_pending;
        issue      = id_valid && !hazard && ex_ready && !flush;
        stall      = id_valid && !flush && (hazard || !ex_ready);
        load_dest  = issue && id_writes && (id_dest_addr != 5'd0);
    end

    // Pending-register view; register 0 is hard-wired idle.
    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    // Counters and execute bubble advance only when execute accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            ex_bubble <= 1'b1;
        end else begin
            cnt[0] <= '0;
            if (ex_ready) begin
                for (int r = 1; r < NUM_REGS; r++) begin
                    if (load_dest && (id_dest_addr == 5'(r))) begin
                        cnt[r] <= id_is_load ? LOAD_CNT : ALU_CNT;
                    end else if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - CNT_W'(1);
                    end
                end
                ex_bubble <= !issue;
            end
        end
    end

    // Stall cycles are counted even while the pipeline is frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != STALL_MAX)) begin
            stall_count <= stall_count + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dest_addr;
    logic        id_writes;
    logic        id_is_load;
    logic        ex_ready;
    logic        flush;
    logic        issue;
    logic        stall;
    logic        ex_bubble;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.ALU_LAT(1), .LOAD_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest_addr (id_dest_addr),
        .id_writes    (id_writes),
        .id_is_load   (id_is_load),
        .ex_ready     (ex_ready),
        .flush        (flush),
        .issue        (issue),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .busy_mask    (busy_mask),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic [4:0]  dest;
        logic        wr;
        logic        ld;
        logic        rdy;
        logic        fl;
        logic        e_issue;
        logic        e_stall;
        logic        e_bubble;
        logic [31:0] e_busy;
        logic [15:0] e_sc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic valid, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic [4:0] dest, input logic wr,
        input logic ld, input logic rdy, input logic fl,
        input logic e_issue, input logic e_stall, input logic e_bubble,
        input logic [31:0] e_busy, input logic [15:0] e_sc);
        vec_t v;
        v.rst_n = rst; v.valid = valid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.dest = dest; v.wr = wr; v.ld = ld; v.rdy = rdy; v.fl = fl;
        v.e_issue = e_issue; v.e_stall = e_stall; v.e_bubble = e_bubble;
        v.e_busy = e_busy; v.e_sc = e_sc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; id_valid = v.valid; id_rs_addr = v.rs; id_rt_addr = v.rt;
        id_uses_rs = v.urs; id_uses_rt = v.urt; id_dest_addr = v.dest;
        id_writes = v.wr; id_is_load = v.ld; ex_ready = v.rdy; flush = v.fl;
    endtask

    task automatic check_all(input string tag, input logic e_issue, input logic e_stall,
                             input logic e_bubble, input logic [31:0] e_busy,
                             input logic [15:0] e_sc);
        chk({tag, " issue"},     32'(issue),       32'(e_issue));
        chk({tag, " stall"},     32'(stall),       32'(e_stall));
        chk({tag, " ex_bubble"}, 32'(ex_bubble),   32'(e_bubble));
        chk({tag, " busy_mask"}, busy_mask,        e_busy);
        chk({tag, " stall_cnt"}, 32'(stall_count), 32'(e_sc));
    endtask

    initial begin
        vec_t idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 1, 32'h0, 16'd0);

        //         rst v  rs  rt  urs urt dst wr ld rdy fl  iss stl bub busy          sc
        // load $5, dependent stalls 2 cycles
        vecs.push_back(mk(1, 1, 0,  0,  0, 0,  5, 1, 1, 1, 0,  1, 0, 1, 32'h0,        0));
        vecs.push_back(mk(1, 1, 5,  0,  1, 0,  6, 1, 0, 1, 0,  0, 1, 0, 32'h20,       0));
        vecs.push_back(mk(1, 1, 5,  0,  1, 0,  6, 1, 0, 1, 0,  0, 1, 1, 32'h20,       1));
        vecs.push_back(mk(1, 1, 5,  0,  1, 0,  6, 1, 0, 1, 0,  1, 0, 1, 32'h0,        2));
        // write to $0 never pending, reading $0 never hazards
        vecs.push_back(mk(1, 1, 0,  0,  0, 0,  0, 1, 0, 1, 0,  1, 0, 0, 32'h40,       2));
        vecs.push_back(mk(1, 1, 0,  0,  1, 1,  0, 0, 0, 1, 0,  1, 0, 0, 32'h0,        2));
        // load $7, dependent frozen 3 cycles then 2 hazard stalls
        vecs.push_back(mk(1, 1, 0,  0,  0, 0,  7, 1, 1, 1, 0,  1, 0, 0, 32'h0,        2));
        vecs.push_back(mk(1, 1, 0,  7,  0, 1,  0, 0, 0, 0, 0,  0, 1, 0, 32'h80,       2));
        vecs.push_back(mk(1, 1, 0,  7,  0, 1,  0, 0, 0, 0, 0,  0, 1, 0, 32'h80,       3));
        vecs.push_back(mk(1, 1, 0,  7,  0, 1,  0, 0, 0, 0, 0,  0, 1, 0, 32'h80,       4));
        vecs.push_back(mk(1, 1, 0,  7,  0, 1,  0, 0, 0, 1, 0,  0, 1, 0, 32'h80,       5));
        vecs.push_back(mk(1, 1, 0,  7,  0, 1,  0, 0, 0, 1, 0,  0, 1, 1, 32'h80,       6));
        vecs.push_back(mk(1, 1, 0,  7,  0, 1,  0, 0, 0, 1, 0,  1, 0, 1, 32'h0,        7));
        // flush while stalled on $9
        vecs.push_back(mk(1, 1, 0,  0,  0, 0,  9, 1, 1, 1, 0,  1, 0, 0, 32'h0,        7));
        vecs.push_back(mk(1, 1, 9,  0,  1, 0, 10, 1, 0, 1, 0,  0, 1, 0, 32'h200,      7));
        vecs.push_back(mk(1, 1, 9,  0,  1, 0, 10, 1, 0, 1, 1,  0, 0, 1, 32'h200,      8));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0, 1, 0,  0, 0, 1, 32'h0,        8));
        // self-dependent load $3, next reader stalls 2
        vecs.push_back(mk(1, 1, 3,  0,  1, 0,  3, 1, 1, 1, 0,  1, 0, 1, 32'h0,        8));
        vecs.push_back(mk(1, 1, 0,  3,  0, 1,  0, 0, 0, 1, 0,  0, 1, 0, 32'h8,        8));
        vecs.push_back(mk(1, 1, 0,  3,  0, 1,  0, 0, 0, 1, 0,  0, 1, 1, 32'h8,        9));
        vecs.push_back(mk(1, 1, 0,  3,  0, 1,  0, 0, 0, 1, 0,  1, 0, 1, 32'h0,       10));
        // reset mid-stall, waiting instruction issues right after release
        vecs.push_back(mk(1, 1, 0,  0,  0, 0, 12, 1, 1, 1, 0,  1, 0, 0, 32'h0,       10));
        vecs.push_back(mk(0, 1, 12, 0,  1, 0,  0, 0, 0, 1, 0,  0, 1, 0, 32'h1000,    10));
        vecs.push_back(mk(1, 1, 12, 0,  1, 0,  0, 0, 0, 1, 0,  1, 0, 1, 32'h0,        0));
        // reset overrides a simultaneous load issue
        vecs.push_back(mk(0, 1, 0,  0,  0, 0, 13, 1, 1, 1, 0,  1, 0, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0, 1, 0,  0, 0, 1, 32'h0,        0));
        // ALU producer: dependent (both sources) stalls exactly 1
        vecs.push_back(mk(1, 1, 0,  0,  0, 0, 20, 1, 0, 1, 0,  1, 0, 1, 32'h0,        0));
        vecs.push_back(mk(1, 1, 20, 20, 1, 1,  0, 0, 0, 1, 0,  0, 1, 0, 32'h100000,   0));
        vecs.push_back(mk(1, 1, 20, 20, 1, 1,  0, 0, 0, 1, 0,  1, 0, 1, 32'h0,        1));
        // unused source never hazards; freeze holds counter and bubble
        vecs.push_back(mk(1, 1, 0,  0,  0, 0,  4, 1, 1, 1, 0,  1, 0, 0, 32'h0,        1));
        vecs.push_back(mk(1, 1, 4,  0,  0, 1,  0, 0, 0, 1, 0,  1, 0, 0, 32'h10,       1));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 32'h10,       1));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0, 1, 0,  0, 0, 0, 32'h10,       1));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0,  0, 0, 0, 1, 0,  0, 0, 1, 32'h0,        1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_issue, vecs[i].e_stall,
                      vecs[i].e_bubble, vecs[i].e_busy, vecs[i].e_sc);
            @(posedge clk);
            #1;
        end

        // Saturation: pending load on $15 plus frozen dependent for 70000 cycles
        drive(idle);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; id_valid = 1'b1; id_dest_addr = 5'd15; id_writes = 1'b1; id_is_load = 1'b1;
        @(posedge clk); #1;
        id_writes = 1'b0; id_is_load = 1'b0; id_dest_addr = 5'd0;
        id_rs_addr = 5'd15; id_uses_rs = 1'b1; ex_ready = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", 32'(stall_count), 32'h0000FFFE);
        @(posedge clk); #1;
        chk("sat_hit", 32'(stall_count), 32'h0000FFFF);
        repeat (4465) @(posedge clk);
        #1;
        chk("sat_hold", 32'(stall_count), 32'h0000FFFF);
        chk("sat_busy", busy_mask, 32'h00008000);
        chk("sat_stall", 32'(stall), 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        id_valid = 1'b0;
        #1;
        chk("rst2 stall_cnt", 32'(stall_count), 32'h0);
        chk("rst2 busy_mask", busy_mask, 32'h0);
        chk("rst2 ex_bubble", 32'(ex_bubble), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, meaning the number of stall cycles a dependent instruction waits after an ALU-result producer issues (legal range 1..3).
REQ-002 The block SHALL have parameter LOAD_LAT, default 2, meaning the number of stall cycles a dependent instruction waits after a load producer issues (legal range 1..3).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 id_valid  input  1  the decode stage holds a valid instruction.
REQ-006 id_rs_addr  input  5  first source register number.
REQ-007 id_rt_addr  input  5  second source register number.
REQ-008 id_uses_rs  input  1  the instruction reads rs.
REQ-009 id_uses_rt  input  1  the instruction reads rt.
REQ-010 id_dest_addr  input  5  destination register number.
REQ-011 id_writes  input  1  the instruction writes its destination.
REQ-012 id_is_load  input  1  the instruction is a load (selects LOAD_LAT).
REQ-013 ex_ready  input  1  the execute stage accepts an instruction this cycle; 0 freezes the pipeline.
REQ-014 flush  input  1  kills the decode-stage instruction this cycle (branch taken).
REQ-015 issue  output  1  combinational; the decode instruction advances to execute at this edge.
REQ-016 stall  output  1  combinational; the decode stage must hold its instruction.
REQ-017 ex_bubble  output  1  registered; execute stage holds a NOP this cycle.
REQ-018 busy_mask  output  32  combinational; bit r = 1 while register r has a pending counter.
REQ-019 stall_count  output  16  registered saturating count of stall cycles.

Function
REQ-020 The block SHALL hold one 2-bit pending counter cnt[r] per register r = 1..31; register 0 SHALL never be pending, and busy_mask[0] SHALL be 0.
REQ-021 hazard SHALL be 1 iff (id_uses_rs and id_rs_addr != 0 and cnt[id_rs_addr] != 0) or (id_uses_rt and id_rt_addr != 0 and cnt[id_rt_addr] != 0).
REQ-022 issue SHALL equal id_valid and not hazard and ex_ready and not flush.
REQ-023 stall SHALL equal id_valid and not flush and (hazard or not ex_ready).
REQ-024 With ex_ready = 1, every nonzero cnt SHALL decrement by 1 per cycle.
REQ-025 With ex_ready = 1 and issue = 1 and id_writes = 1 and id_dest_addr != 0, cnt[id_dest_addr] SHALL be loaded with LOAD_LAT if id_is_load, else ALU_LAT; the load SHALL override the decrement of the same register in that cycle.
REQ-026 With ex_ready = 0, all cnt, ex_bubble and the scoreboard state SHALL hold unchanged; stall_count SHALL still count.
REQ-027 With ex_ready = 1, ex_bubble SHALL be loaded with not issue.
REQ-028 flush SHALL take priority over hazard: issue = 0, stall = 0, and no cnt is loaded; counters of already-issued producers SHALL continue to decrement.
REQ-029 A self-dependent instruction (source equals its own destination) SHALL test hazard against the pre-update counter only.
REQ-030 stall_count SHALL increment by 1 each cycle stall = 1 and SHALL saturate at 16'hFFFF.
REQ-031 A dependent instruction issued directly after a producer SHALL stall exactly ALU_LAT cycles (ALU) or LOAD_LAT cycles (load), given ex_ready = 1 throughout.

Reset
REQ-032 While rst_n = 0 at a rising edge, all cnt SHALL clear to 0, ex_bubble SHALL be 1, and stall_count SHALL be 0; busy_mask SHALL then read 0.
REQ-033 Reset SHALL override all simultaneous issue, flush and ex_ready activity, including reset asserted mid-stall, after which a waiting instruction SHALL issue on the first cycle after release.

Verification
REQ-034 Load to $5 (LOAD_LAT=2), then add reading rs=$5 -> stall=1 for 2 cycles, issue=1 on the 3rd cycle, stall_count=2, ex_bubble=1 for 2 cycles.
REQ-035 ALU write to $0, then instruction reading $0 -> no stall, busy_mask=0.
REQ-036 Load to $7, dependent instruction waiting, ex_ready=0 for 3 cycles -> cnt[7] held at 2, stall=1 throughout, stall_count=3 plus 2 further hazard stalls after ex_ready returns.
REQ-037 Dependent instruction stalled on $9 while flush=1 -> issue=0, stall=0, cnt[9] keeps decrementing, next cycle ex_bubble=1.
REQ-038 Load to $3 with id_rs_addr=$3 (self-dependent) -> issues without stall; cnt[3]=2; the next reader of $3 stalls 2 cycles.
REQ-039 Force stall for 70000 cycles -> stall_count saturates at 16'hFFFF; rst_n=0 for one edge -> stall_count=0, busy_mask=0, ex_bubble=1.
